// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver state encoding.
// Also used by the parametrised transmitter.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead output FIFO for received frames.
// dout always presents the entry at the read pointer.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Power-of-two depth: pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch-rejecting start detection
// and a show-ahead valid/ready output FIFO.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int MSB_FIRST    = 1,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          serial_in,
   output logic                          rts,
   output logic [DATA_BITS-1:0]          data_out,
   output logic                          data_out_valid,
   input  logic                          data_out_ready,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            state_n;
   logic                 rx_meta;
   logic                 rx_s;
   logic [TW-1:0]        tick;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr_int;
   logic                 perr_int;
   logic                 sample;
   logic                 sym_end;
   logic                 last_stop;
   logic                 par_x;
   logic                 frame_push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS+1:0] head;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= serial_in;
         rx_s    <= rx_meta;
      end
   end

   assign sample    = (tick == T_MID);
   assign sym_end   = (tick == T_LAST);
   assign last_stop = (STOP_BITS == 1) || stop_idx;
   assign par_x     = (^shreg) ^ rx_s;

   always_ff @(posedge clock) begin
      if (reset) state <= RX_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         RX_IDLE:
            if (rts && !rx_s) state_n = RX_START;
         RX_START:
            if (sample && rx_s) state_n = RX_IDLE;
            else if (sym_end)   state_n = RX_DATA;
         RX_DATA:
            if (sym_end && bit_idx == B_LAST)
               state_n = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
         RX_PARITY:
            if (sym_end) state_n = RX_STOP;
         RX_STOP:
            if (sym_end && last_stop) state_n = RX_IDLE;
         default:
            state_n = RX_IDLE;
      endcase
   end

   always_comb begin
      rts        = (state == RX_IDLE) && !fifo_full;
      frame_push = (state == RX_STOP) && sym_end && last_stop;
   end

   // Tick restarts on every symbol boundary and on any return to idle.
   always_ff @(posedge clock) begin
      if (reset)
         tick <= '0;
      else if (state == RX_IDLE || state_n == RX_IDLE || sym_end)
         tick <= '0;
      else
         tick <= tick + TW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset || state != RX_DATA) bit_idx <= '0;
      else if (sym_end)              bit_idx <= bit_idx + BW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset || state != RX_STOP) stop_idx <= 1'b0;
      else if (sym_end)              stop_idx <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shreg    <= '0;
         ferr_int <= 1'b0;
         perr_int <= 1'b0;
      end else begin
         if (state == RX_IDLE && state_n == RX_START) begin
            ferr_int <= 1'b0;
            perr_int <= 1'b0;
         end
         if (sample) begin
            unique case (1'b1)
               state == RX_DATA:
                  shreg <= (MSB_FIRST != 0)
                         ? {shreg[DATA_BITS-2:0], rx_s}
                         : {rx_s, shreg[DATA_BITS-1:1]};
               state == RX_PARITY:
                  perr_int <= (PARITY == PARITY_ODD) ? ~par_x : par_x;
               state == RX_STOP:
                  if (!rx_s) ferr_int <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (frame_push),
      .pop   (data_out_ready),
      .din   ({shreg, ferr_int, perr_int}),
      .dout  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign data_out_valid = !fifo_empty;
   assign data_out       = head[DATA_BITS+1:2];
   assign frame_err      = data_out_valid && head[1];
   assign parity_err     = (PARITY != PARITY_NONE) && data_out_valid && head[0];

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four differently configured receivers
// checked against a frame-level model and scoreboard.
module tb_uart_rx_param;

   localparam int CPB   [4] = '{16, 8, 4, 16};
   localparam int NB    [4] = '{8, 7, 8, 8};
   localparam int MSBF  [4] = '{1, 0, 1, 1};
   localparam int PAR   [4] = '{0, 0, 1, 2};
   localparam int NSTOP [4] = '{1, 2, 1, 1};
   localparam int DEPTH [4] = '{4, 4, 4, 2};

   typedef struct {
      int         u;
      logic [8:0] d;
      bit         fe;
      bit         pe;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] ser;
   logic [3:0] rdy;
   logic [3:0] vld;
   logic [3:0] fe;
   logic [3:0] pe;
   logic [3:0] rts;
   logic [8:0] dout [4];
   logic [2:0] cnt  [4];

   logic [7:0] d_a, d_c, d_d;
   logic [6:0] d_b;
   logic [2:0] c_a, c_b, c_c;
   logic [1:0] c_d;
   logic       v_a, v_b, v_c, v_d;
   logic       f_a, f_b, f_c, f_d;
   logic       p_a, p_b, p_c, p_d;
   logic       r_a, r_b, r_c, r_d;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   fall_cyc [4];
   int   rise_cyc [4];
   logic [3:0] vld_q = '0;
   exp_t sb [$];

   always #5 clock = ~clock;

   assign vld = {v_d, v_c, v_b, v_a};
   assign fe  = {f_d, f_c, f_b, f_a};
   assign pe  = {p_d, p_c, p_b, p_a};
   assign rts = {r_d, r_c, r_b, r_a};
   assign dout[0] = {1'b0, d_a};
   assign dout[1] = {2'b0, d_b};
   assign dout[2] = {1'b0, d_c};
   assign dout[3] = {1'b0, d_d};
   assign cnt[0] = c_a;
   assign cnt[1] = c_b;
   assign cnt[2] = c_c;
   assign cnt[3] = {1'b0, c_d};

   uart_rx_param #(
      .CLKS_PER_BIT(CPB[0]), .DATA_BITS(NB[0]), .MSB_FIRST(MSBF[0]),
      .PARITY(PAR[0]), .STOP_BITS(NSTOP[0]), .FIFO_DEPTH(DEPTH[0])
   ) dut_a (
      .clock(clock), .reset(reset), .serial_in(ser[0]), .rts(r_a),
      .data_out(d_a), .data_out_valid(v_a), .data_out_ready(rdy[0]),
      .frame_err(f_a), .parity_err(p_a), .fifo_count(c_a)
   );

   uart_rx_param #(
      .CLKS_PER_BIT(CPB[1]), .DATA_BITS(NB[1]), .MSB_FIRST(MSBF[1]),
      .PARITY(PAR[1]), .STOP_BITS(NSTOP[1]), .FIFO_DEPTH(DEPTH[1])
   ) dut_b (
      .clock(clock), .reset(reset), .serial_in(ser[1]), .rts(r_b),
      .data_out(d_b), .data_out_valid(v_b), .data_out_ready(rdy[1]),
      .frame_err(f_b), .parity_err(p_b), .fifo_count(c_b)
   );

   uart_rx_param #(
      .CLKS_PER_BIT(CPB[2]), .DATA_BITS(NB[2]), .MSB_FIRST(MSBF[2]),
      .PARITY(PAR[2]), .STOP_BITS(NSTOP[2]), .FIFO_DEPTH(DEPTH[2])
   ) dut_c (
      .clock(clock), .reset(reset), .serial_in(ser[2]), .rts(r_c),
      .data_out(d_c), .data_out_valid(v_c), .data_out_ready(rdy[2]),
      .frame_err(f_c), .parity_err(p_c), .fifo_count(c_c)
   );

   uart_rx_param #(
      .CLKS_PER_BIT(CPB[3]), .DATA_BITS(NB[3]), .MSB_FIRST(MSBF[3]),
      .PARITY(PAR[3]), .STOP_BITS(NSTOP[3]), .FIFO_DEPTH(DEPTH[3])
   ) dut_d (
      .clock(clock), .reset(reset), .serial_in(ser[3]), .rts(r_d),
      .data_out(d_d), .data_out_valid(v_d), .data_out_ready(rdy[3]),
      .frame_err(f_d), .parity_err(p_d), .fifo_count(c_d)
   );

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      for (int i = 0; i < 4; i++)
         if (vld[i] && !vld_q[i]) rise_cyc[i] <= cyc;
      vld_q <= vld;
   end

   always @(negedge clock) begin
      if (!reset && dut_a.frame_push && dut_a.fifo_full) begin
         miscompares++;
         $display("FAIL push_when_full: push=1 with count=%0d, required no push", c_a);
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int occ(input int u);
      int n = 0;
      foreach (sb[i]) if (sb[i].u == u) n++;
      return n;
   endfunction

   function automatic bit model_perr(input int u, input logic [8:0] m, input bit p);
      int s;
      s = $countones(m) + int'(p);
      if (PAR[u] == 1) return (s % 2) != 0;
      if (PAR[u] == 2) return (s % 2) == 0;
      return 1'b0;
   endfunction

   function automatic void sb_pop(input int u);
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].u == u) begin
            sb.delete(i);
            return;
         end
   endfunction

   function automatic int frame_cycles(input int u);
      return CPB[u] * (1 + NB[u] + (PAR[u] != 0 ? 1 : 0) + NSTOP[u]);
   endfunction

   // Drives one frame plus one idle symbol; the model records what the
   // receiver should deliver if its FIFO had room when the frame began.
   task automatic send_frame(input int u, input logic [8:0] d,
                             input bit bad_stop, input bit pbit);
      bit         bits [$];
      logic [8:0] m;
      exp_t       e;
      m = d & 9'((1 << NB[u]) - 1);
      bits.push_back(1'b0);
      for (int i = 0; i < NB[u]; i++) begin
         if (MSBF[u] != 0) bits.push_back(((m >> (NB[u] - 1 - i)) & 9'd1) != 0);
         else              bits.push_back(((m >> i) & 9'd1) != 0);
      end
      if (PAR[u] != 0) bits.push_back(pbit);
      for (int i = 0; i < NSTOP[u]; i++)
         bits.push_back(!(bad_stop && i == NSTOP[u] - 1));
      if (occ(u) < DEPTH[u]) begin
         e.u  = u;
         e.d  = m;
         e.fe = bad_stop;
         e.pe = model_perr(u, m, pbit);
         sb.push_back(e);
      end
      fall_cyc[u] = cyc;
      foreach (bits[i]) begin
         ser[u] = bits[i];
         repeat (CPB[u]) @(posedge clock);
         #1;
      end
      ser[u] = 1'b1;
      repeat (CPB[u]) @(posedge clock);
      #1;
   endtask

   task automatic drain_one(input int u, input string tag);
      int   n = 0;
      int   idx = -1;
      exp_t e;
      while (!vld[u] && n < 4000) begin
         @(posedge clock);
         #1;
         n++;
      end
      vectors++;
      if (!vld[u]) begin
         miscompares++;
         $display("FAIL %s valid: got %b, required 1 within 4000 cycles", tag, vld[u]);
         return;
      end
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].u == u && idx < 0) idx = i;
      if (idx < 0) begin
         miscompares++;
         $display("FAIL %s extra entry: got data=%h, required empty", tag, dout[u]);
      end else begin
         e = sb[idx];
         sb.delete(idx);
         vectors++;
         if (dout[u] !== e.d) begin
            miscompares++;
            $display("FAIL %s data: got %h, required %h", tag, dout[u], e.d);
         end
         vectors++;
         if (fe[u] !== e.fe) begin
            miscompares++;
            $display("FAIL %s frame_err: got %b, required %b", tag, fe[u], e.fe);
         end
         vectors++;
         if (pe[u] !== e.pe) begin
            miscompares++;
            $display("FAIL %s parity_err: got %b, required %b", tag, pe[u], e.pe);
         end
      end
      rdy[u] = 1'b1;
      @(posedge clock);
      #1;
      rdy[u] = 1'b0;
   endtask

   task automatic test_reset();
      for (int u = 0; u < 4; u++) begin
         vectors++;
         if (vld[u] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid[%0d]: got %b, required 0", u, vld[u]);
         end
         vectors++;
         if (cnt[u] !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count[%0d]: got %0d, required 0", u, cnt[u]);
         end
         vectors++;
         if (rts[u] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rts[%0d]: got %b, required 1", u, rts[u]);
         end
         vectors++;
         if (fe[u] !== 1'b0 || pe[u] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags[%0d]: got fe=%b pe=%b, required 0 0", u, fe[u], pe[u]);
         end
      end
   endtask

   // Valid rises 2 synchroniser cycles + 1 detect cycle + one full frame
   // after the serial line falls.
   task automatic test_latency();
      for (int u = 0; u < 4; u++) begin
         send_frame(u, 9'h0A5, 1'b0, 1'b0);
         vectors++;
         if (rise_cyc[u] - fall_cyc[u] != 3 + frame_cycles(u)) begin
            miscompares++;
            $display("FAIL latency[%0d]: got %0d cycles, required %0d",
                     u, rise_cyc[u] - fall_cyc[u], 3 + frame_cycles(u));
         end
         vectors++;
         if (cnt[u] !== 3'd1) begin
            miscompares++;
            $display("FAIL latency_count[%0d]: got %0d, required 1", u, cnt[u]);
         end
         drain_one(u, "latency");
      end
   endtask

   task automatic test_lsb_first();
      send_frame(1, 9'h041, 1'b0, 1'b0);
      drain_one(1, "lsb_good");
      send_frame(1, 9'h041, 1'b1, 1'b0);
      drain_one(1, "lsb_bad_stop");
   endtask

   task automatic test_parity();
      send_frame(2, 9'h00F, 1'b0, 1'b1);
      drain_one(2, "even_p1");
      send_frame(2, 9'h00F, 1'b0, 1'b0);
      drain_one(2, "even_p0");
      send_frame(3, 9'h00F, 1'b0, 1'b1);
      drain_one(3, "odd_p1");
   endtask

   task automatic test_glitch();
      ser[0] = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      ser[0] = 1'b1;
      repeat (3 + CPB[0] / 2 - 4) @(posedge clock);
      #1;
      vectors++;
      if (rts[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_in_start rts: got %b, required 0", rts[0]);
      end
      @(posedge clock);
      #1;
      vectors++;
      if (rts[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_reject rts: got %b, required 1", rts[0]);
      end
      repeat (2 * CPB[0]) @(posedge clock);
      #1;
      vectors++;
      if (cnt[0] !== 3'd0 || vld[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_no_push: got count=%0d valid=%b, required 0 0", cnt[0], vld[0]);
      end
      send_frame(0, 9'h05A, 1'b0, 1'b0);
      drain_one(0, "after_glitch");
   endtask

   task automatic test_fifo_full();
      logic [8:0] pat [4] = '{9'h11, 9'h22, 9'h33, 9'h44};
      rdy[0] = 1'b0;
      foreach (pat[i]) send_frame(0, pat[i], 1'b0, 1'b0);
      vectors++;
      if (cnt[0] !== 3'd4 || rts[0] !== 1'b0 || dout[0] !== 9'h11) begin
         miscompares++;
         $display("FAIL full: got count=%0d rts=%b data=%h, required 4 0 11",
                  cnt[0], rts[0], dout[0]);
      end
      send_frame(0, 9'h055, 1'b0, 1'b0);
      vectors++;
      if (cnt[0] !== 3'd4 || dout[0] !== 9'h11) begin
         miscompares++;
         $display("FAIL full_ignore: got count=%0d data=%h, required 4 11", cnt[0], dout[0]);
      end
      rdy[0] = 1'b1;
      @(posedge clock);
      #1;
      rdy[0] = 1'b0;
      sb_pop(0);
      vectors++;
      if (dout[0] !== 9'h22 || cnt[0] !== 3'd3 || rts[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL full_pop: got data=%h count=%0d rts=%b, required 22 3 1",
                  dout[0], cnt[0], rts[0]);
      end
      repeat (3) drain_one(0, "full_drain");
      repeat (4 * CPB[0]) @(posedge clock);
      #1;
      vectors++;
      if (vld[0] !== 1'b0 || cnt[0] !== 3'd0) begin
         miscompares++;
         $display("FAIL full_dropped: got valid=%b count=%0d, required 0 0", vld[0], cnt[0]);
      end
   endtask

   // Pop the held entry in exactly the cycle the next frame is pushed.
   task automatic test_back_to_back();
      rdy[0] = 1'b0;
      send_frame(0, 9'h066, 1'b0, 1'b0);
      fork
         send_frame(0, 9'h077, 1'b0, 1'b0);
         begin
            repeat (2 + frame_cycles(0)) @(posedge clock);
            #1;
            vectors++;
            if (dout[0] !== 9'h066 || cnt[0] !== 3'd1) begin
               miscompares++;
               $display("FAIL b2b_before: got data=%h count=%0d, required 66 1",
                        dout[0], cnt[0]);
            end
            rdy[0] = 1'b1;
            @(posedge clock);
            #1;
            rdy[0] = 1'b0;
            sb_pop(0);
            vectors++;
            if (cnt[0] !== 3'd1 || dout[0] !== 9'h077) begin
               miscompares++;
               $display("FAIL b2b_push_pop: got count=%0d data=%h, required 1 77",
                        cnt[0], dout[0]);
            end
         end
      join
      drain_one(0, "b2b_drain");
   endtask

   task automatic test_reset_mid_frame();
      ser[0] = 1'b0;
      repeat (3 + CPB[0] + 3 * CPB[0] + CPB[0] / 2) @(posedge clock);
      #1;
      vectors++;
      if (rts[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL midframe_busy rts: got %b, required 0", rts[0]);
      end
      reset  = 1'b1;
      ser[0] = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
      @(posedge clock);
      #1;
      vectors++;
      if (vld[0] !== 1'b0 || cnt[0] !== 3'd0 || rts[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL midframe_reset: got valid=%b count=%0d rts=%b, required 0 0 1",
                  vld[0], cnt[0], rts[0]);
      end
      send_frame(0, 9'h03C, 1'b0, 1'b0);
      drain_one(0, "after_reset");
   endtask

   task automatic test_random();
      for (int it = 0; it < 14; it++) begin
         int u;
         int k;
         u = $urandom_range(0, 3);
         k = $urandom_range(1, DEPTH[u]);
         for (int j = 0; j < k; j++)
            send_frame(u, 9'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
         vectors++;
         if (cnt[u] !== 3'(k)) begin
            miscompares++;
            $display("FAIL random_count[%0d]: got %0d, required %0d", u, cnt[u], k);
         end
         for (int j = 0; j < k; j++) drain_one(u, "random");
      end
   endtask

   initial begin
      ser   = '1;
      rdy   = '0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      test_reset();
      test_latency();
      test_lsb_first();
      test_parity();
      test_glitch();
      test_fifo_full();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
